imem_loader: RTL

Synthesizable program loader that fills the instruction memory of `single_cycle_risc` from a byte stream and holds the core in reset until loading completes. It is the hardware replacement for the bench-side `$readmemh` load. It sits between a byte source (UART receiver or debug port) and the write port of `imem_inst`. It drives the core reset, so the core never fetches from a partially written image.

---
 rtl/risc_pkg.sv | 20 ++
 rtl/word_assembler.sv | 33 +++
 rtl/imem_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the single_cycle_risc codebase: datapath widths,
// the program-loader frame sync byte and the loader state encoding.
package risc_pkg;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 32;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit word.
// The first byte of a word lands in bits [7:0]. On the byte that completes
// a word, word_valid pulses for that cycle and word presents the full value
// combinationally, so the caller can register it on the same edge.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;

    assign word_valid = byte_valid && (byte_cnt == 2'd3);
    assign word       = {byte_data, partial};

    // Shift each accepted byte in from the top so the oldest ends up lowest.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            partial  <= '0;
        end else if (byte_valid) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            byte_cnt <= byte_cnt + 2'd1;
            partial  <= {byte_data, partial[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program loader: fills the instruction memory from a byte stream framed as
//   A5, LEN0, LEN1, N x 4 bytes (little-endian) [, XOR checksum byte]
// and holds the core in reset until the whole image has been written.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR-of-data-bytes checksum before the core is released.
module imem_loader
    import risc_pkg::*;
#(
    parameter int                 DWIDTH    = risc_pkg::DWIDTH,
    parameter int                 AWIDTH    = risc_pkg::AWIDTH,
    parameter int                 DEPTH     = 256,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [AWIDTH-1:0] imem_addr,
    output logic [DWIDTH-1:0] imem_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [16:0] MAX_WORDS = 17'(DEPTH);

    loader_state_t     state;
    logic              ready_q;
    logic [7:0]        len_lo;
    logic [15:0]       word_count;
    logic [15:0]       word_idx;
    logic [AWIDTH-1:0] wr_ptr;
    logic [15:0]       len_in;
    logic              accept;
    logic              asm_valid;
    logic [31:0]       asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // NOTE: the registered ready flag is also gated by reset so the port
    // drops immediately while reset is high and rises as soon as it falls.
    assign in_ready = ready_q && !reset;
    assign accept   = in_valid && in_ready;
    assign len_in   = {in_data, len_lo};

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (asm_valid),
        .word       (asm_word)
    );

    // Frame FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SYNC;
            ready_q    <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            len_lo     <= '0;
            word_count <= '0;
            word_idx   <= '0;
            wr_ptr     <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                SYNC: begin
                    if (accept && (in_data == LOADER_SYNC)) begin
                        state <= LEN0;
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo <= in_data;
                        state  <= LEN1;
                    end
                end
                LEN1: begin
                    if (accept) begin
                        word_count <= len_in;
                        if (len_in == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state      <= DONE;
                            ready_q    <= 1'b0;
                            load_done  <= 1'b1;
                            core_reset <= 1'b0;
`endif
                        end else if ({1'b0, len_in} > MAX_WORDS) begin
                            state      <= ERROR;
                            ready_q    <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        csum <= csum ^ in_data;
                    end
`endif
                    if (asm_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wr_ptr;
                        imem_wdata <= DWIDTH'(asm_word);
                        wr_ptr     <= wr_ptr + AWIDTH'(4);
                        word_idx   <= word_idx + 16'd1;
                        if (word_idx == word_count - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state      <= DONE;
                            ready_q    <= 1'b0;
                            load_done  <= 1'b1;
                            core_reset <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (in_data == csum) begin
                            state      <= DONE;
                            load_done  <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // DONE and ERROR are terminal; only reset leaves them.
                end
            endcase
        end
    end

endmodule
